// File: rtl/fifo_uart_tx.sv
// Drains fifo_top one word at a time and serialises it as start, LSB-first data, stop.
// Optional even-parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] POP    = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  logic [2:0]            state, state_nx;
  logic [CNT_WIDTH-1:0]  baud, baud_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] shift, shift_nx;
  logic                  baud_end;
  logic                  tx_nx, rd_nx, busy_nx, done_nx;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_bit, par_nx;
`endif

  assign baud_end = (baud == BAUD_LAST);

  // Next-state and datapath; outputs are decoded from the next state so they can be registered.
  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_cnt;
    shift_nx = shift;
`ifdef FIFO_UART_TX_PARITY_EN
    par_nx   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (!i_fifo_empty) state_nx = POP;
        else               state_nx = IDLE;
      end
      POP:  state_nx = LOAD;
      LOAD: begin
        shift_nx = i_fifo_data;
        baud_nx  = {CNT_WIDTH{1'b0}};
        bit_nx   = {BIT_W{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
        par_nx   = even_parity(i_fifo_data);
`endif
        state_nx = START;
      end
      START: begin
        if (baud_end) begin
          baud_nx  = {CNT_WIDTH{1'b0}};
          bit_nx   = {BIT_W{1'b0}};
          state_nx = DATA;
        end else begin
          baud_nx  = baud + CNT_WIDTH'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nx  = {CNT_WIDTH{1'b0}};
          shift_nx = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nx   = {BIT_W{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_nx   = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nx  = baud + CNT_WIDTH'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_nx  = {CNT_WIDTH{1'b0}};
          state_nx = STOP;
        end else begin
          baud_nx  = baud + CNT_WIDTH'(1);
        end
      end
`endif
      STOP: begin
        // Empty flag is only looked at here and in IDLE; a waiting word starts the next frame at once.
        if (baud_end) begin
          baud_nx  = {CNT_WIDTH{1'b0}};
          state_nx = i_fifo_empty ? IDLE : POP;
        end else begin
          baud_nx  = baud + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        baud_nx  = {CNT_WIDTH{1'b0}};
        bit_nx   = {BIT_W{1'b0}};
      end
    endcase

    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_nx = par_nx;
`endif
      default: tx_nx = 1'b1;
    endcase
    rd_nx   = (state_nx == POP);
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == STOP) && (baud_nx == BAUD_LAST);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      baud      <= {CNT_WIDTH{1'b0}};
      bit_cnt   <= {BIT_W{1'b0}};
      shift     <= {DATA_WIDTH{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
      o_tx      <= 1'b1;
      o_fifo_rd <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nx;
      baud      <= baud_nx;
      bit_cnt   <= bit_nx;
      shift     <= shift_nx;
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit   <= par_nx;
`endif
      o_tx      <= tx_nx;
      o_fifo_rd <= rd_nx;
      o_busy    <= busy_nx;
      o_done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and a
// frame-level reference model predicts the line, pop strobe, busy and done per cycle.
module tb_fifo_uart_tx;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int CW   = 16;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB   = DW + 3;
`else
  localparam int NB   = DW + 2;
`endif
  localparam int FLEN = NB * CPB;
  localparam int MAXC = 2048;

  logic          clk = 1'b0;
  logic          rstn;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          rd, tx, busy, done;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(rd), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rd_word;
  bit            pend_rd   = 1'b0;
  int            underflow = 0;
  int            n_cyc     = 0;
  logic          tr[4][MAXC];
  logic          ex[4][MAXC];
  int            wr_cyc[$];
  logic [DW-1:0] wr_val[$];
  string         sig_name[4] = '{"tx", "rd", "done", "busy"};

  // One clock: apply FIFO read data / writes after the edge, record DUT outputs on the falling edge.
  task automatic step();
    logic [DW-1:0] v;
    @(posedge clk);
    #1;
    if (pend_rd) begin
      fifo_data = rd_word;
      pend_rd   = 1'b0;
    end
    while (wq.size() > 0) begin
      v = wq.pop_front();
      fifo_q.push_back(v);
      wr_cyc.push_back(n_cyc);
      wr_val.push_back(v);
    end
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    if (n_cyc < MAXC) begin
      tr[0][n_cyc] = tx;
      tr[1][n_cyc] = rd;
      tr[2][n_cyc] = done;
      tr[3][n_cyc] = busy;
      n_cyc++;
    end
    if (rd === 1'b1) begin
      if (fifo_q.size() > 0) rd_word = fifo_q.pop_front();
      else underflow++;
      pend_rd = 1'b1;
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic start_trace();
    n_cyc = 0;
    wr_cyc.delete();
    wr_val.delete();
  endtask

  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Reference: a word pops the cycle after the line is free and the FIFO holds data;
  // a frame is POP, LOAD, then NB bits of CPB cycles each.
  function automatic void build_model();
    int wi = 0;
    int npop = 0;
    int busy_until = -1;
    int p, idx;
    for (int c = 0; c < n_cyc; c++) begin
      ex[0][c] = 1'b1; ex[1][c] = 1'b0; ex[2][c] = 1'b0; ex[3][c] = 1'b0;
    end
    for (int c = 0; c < n_cyc; c++) begin
      while (wi < wr_cyc.size() && wr_cyc[wi] <= c) wi++;
      if (c >= busy_until && wi > npop && c + 1 < n_cyc) begin
        p = c + 1;
        ex[1][p] = 1'b1;
        for (int k = 0; k < NB; k++)
          for (int b = 0; b < CPB; b++) begin
            idx = p + 2 + k * CPB + b;
            if (idx < n_cyc) ex[0][idx] = frame_bit(wr_val[npop], k);
          end
        for (int i = p; i <= p + 1 + FLEN && i < n_cyc; i++) ex[3][i] = 1'b1;
        if (p + 1 + FLEN < n_cyc) ex[2][p + 1 + FLEN] = 1'b1;
        busy_until = p + 1 + FLEN;
        npop++;
      end
    end
  endfunction

  function automatic int count_diff(input int s, output int first);
    int n = 0;
    first = -1;
    for (int c = 0; c < n_cyc; c++)
      if (tr[s][c] !== ex[s][c]) begin
        if (first < 0) first = c;
        n++;
      end
    return n;
  endfunction

  function automatic int count_val(input int s, input logic v);
    int n = 0;
    for (int c = 0; c < n_cyc; c++) if (tr[s][c] === v) n++;
    return n;
  endfunction

  function automatic int find_val(input int s, input logic v, input int from);
    for (int c = from; c < n_cyc; c++) if (tr[s][c] === v) return c;
    return -1;
  endfunction

  task automatic test_reset();
    rstn = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
    #1;
    n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (rd !== 1'b0)   begin n_fail++; $display("FAIL reset_rd: got %b want 0", rd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk); rstn = 1'b0;
    start_trace();
    wq.push_back(8'h00);
    steps(12);
    n_checks++; if (tx !== 1'b0)   begin n_fail++; $display("FAIL pre_reset_tx: got %b want 0 (mid data)", tx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    #2; rstn = 1'b1; #1;
    n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    n_checks++; if (rd !== 1'b0)   begin n_fail++; $display("FAIL async_reset_rd: got %b want 0", rd); end
    @(negedge clk); rstn = 1'b0;
    start_trace();
    steps(30);
    n_checks++; if (count_val(1, 1'b1) !== 0) begin n_fail++; $display("FAIL post_reset_pops: got %0d want 0", count_val(1, 1'b1)); end
    n_checks++; if (count_val(0, 1'b0) !== 0) begin n_fail++; $display("FAIL post_reset_line: %0d low cycles, want 0", count_val(0, 1'b0)); end
  endtask

  task automatic test_single_word();
    int errs, first, p, s;
`ifndef FIFO_UART_TX_PARITY_EN
    logic [9:0] seq;
    int bad;
`endif
    start_trace();
    wq.push_back(8'hA5);
    steps(FLEN + 20);
    build_model();
    for (int k = 0; k < 4; k++) begin
      errs = count_diff(k, first);
      n_checks++;
      if (errs !== 0) begin n_fail++; $display("FAIL single_word_%s: %0d cycles differ (first %0d), want 0", sig_name[k], errs, first); end
    end
    n_checks++; if (count_val(1, 1'b1) !== 1) begin n_fail++; $display("FAIL single_word_pops: got %0d want 1", count_val(1, 1'b1)); end
    n_checks++; if (count_val(2, 1'b1) !== 1) begin n_fail++; $display("FAIL single_word_done: got %0d pulses want 1", count_val(2, 1'b1)); end
    p = find_val(1, 1'b1, 0);
    s = find_val(0, 1'b0, 0);
    n_checks++; if (p < 0 || s !== p + 2) begin n_fail++; $display("FAIL pop_to_start: start %0d pop %0d, want start = pop+2", s, p); end
`ifndef FIFO_UART_TX_PARITY_EN
    seq = 10'b1101001010;
    bad = 0;
    if (s >= 0)
      for (int c = 0; c < 40 && s + c < n_cyc; c++) if (tr[0][s + c] !== seq[c / CPB]) bad++;
    n_checks++; if (s < 0 || bad !== 0) begin n_fail++; $display("FAIL a5_bit_sequence: %0d wrong cycles (start %0d), want 0", bad, s); end
    n_checks++; if (s < 0 || s + 39 >= n_cyc || tr[2][s + 39] !== 1'b1) begin n_fail++; $display("FAIL a5_done_position: done not on frame cycle 40 (start %0d)", s); end
`endif
  endtask

  task automatic test_empty_boundary();
    start_trace();
    steps(100);
    n_checks++; if (count_val(1, 1'b1) !== 0) begin n_fail++; $display("FAIL empty_pops: got %0d want 0", count_val(1, 1'b1)); end
    n_checks++; if (count_val(0, 1'b0) !== 0) begin n_fail++; $display("FAIL empty_line: %0d low cycles want 0", count_val(0, 1'b0)); end
    n_checks++; if (count_val(3, 1'b1) !== 0) begin n_fail++; $display("FAIL empty_busy: %0d busy cycles want 0", count_val(3, 1'b1)); end
  endtask

  task automatic test_full_drain();
    int errs, first, prev, cur, badgap;
    start_trace();
    for (int i = 0; i < 8; i++) wq.push_back(8'($urandom));
    steps(8 * (FLEN + 2) + 20);
    build_model();
    for (int k = 0; k < 4; k++) begin
      errs = count_diff(k, first);
      n_checks++;
      if (errs !== 0) begin n_fail++; $display("FAIL full_drain_%s: %0d cycles differ (first %0d), want 0", sig_name[k], errs, first); end
    end
    n_checks++; if (count_val(1, 1'b1) !== 8) begin n_fail++; $display("FAIL full_drain_pops: got %0d want 8", count_val(1, 1'b1)); end
    n_checks++; if (underflow !== 0) begin n_fail++; $display("FAIL full_drain_underflow: got %0d want 0", underflow); end
    badgap = 0;
    prev = find_val(1, 1'b1, 0);
    for (int i = 1; i < 8; i++) begin
      cur = find_val(1, 1'b1, prev + 1);
      if (cur !== prev + FLEN + 2) badgap++;
      prev = cur;
    end
    n_checks++; if (badgap !== 0) begin n_fail++; $display("FAIL full_drain_gap: %0d pops not %0d cycles apart, want 0", badgap, FLEN + 2); end
    n_checks++; if (tr[3][n_cyc - 1] !== 1'b0) begin n_fail++; $display("FAIL full_drain_idle: busy %b at end want 0", tr[3][n_cyc - 1]); end
  endtask

  task automatic test_back_to_back();
    int errs, first, d1, p2;
    start_trace();
    wq.push_back(8'h0F);
    steps(10);
    wq.push_back(8'h3C);
    steps(2 * (FLEN + 2) + 20);
    build_model();
    for (int k = 0; k < 4; k++) begin
      errs = count_diff(k, first);
      n_checks++;
      if (errs !== 0) begin n_fail++; $display("FAIL back_to_back_%s: %0d cycles differ (first %0d), want 0", sig_name[k], errs, first); end
    end
    d1 = find_val(2, 1'b1, 0);
    p2 = (d1 < 0) ? -1 : find_val(1, 1'b1, d1);
    n_checks++; if (d1 < 0 || p2 !== d1 + 1) begin n_fail++; $display("FAIL back_to_back_pop: second pop %0d, done %0d, want done+1", p2, d1); end
  endtask

  task automatic test_random();
    int errs, first;
    start_trace();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0 && fifo_q.size() + wq.size() < 8) wq.push_back(8'($urandom));
      step();
    end
    steps(8 * (FLEN + 2) + 20);
    build_model();
    for (int k = 0; k < 4; k++) begin
      errs = count_diff(k, first);
      n_checks++;
      if (errs !== 0) begin n_fail++; $display("FAIL random_%s: %0d cycles differ (first %0d), want 0", sig_name[k], errs, first); end
    end
    n_checks++; if (count_val(1, 1'b1) !== wr_val.size()) begin n_fail++; $display("FAIL random_pops: got %0d want %0d", count_val(1, 1'b1), wr_val.size()); end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    int errs, first, s1, s2, d1;
    start_trace();
    wq.push_back(8'h07);
    wq.push_back(8'h03);
    steps(2 * (FLEN + 2) + 20);
    build_model();
    for (int k = 0; k < 4; k++) begin
      errs = count_diff(k, first);
      n_checks++;
      if (errs !== 0) begin n_fail++; $display("FAIL parity_%s: %0d cycles differ (first %0d), want 0", sig_name[k], errs, first); end
    end
    s1 = find_val(0, 1'b0, 0);
    s2 = s1 + FLEN + 2;
    d1 = find_val(2, 1'b1, 0);
    n_checks++; if (s1 < 0 || tr[0][s1 + (DW + 1) * CPB + 1] !== 1'b1) begin n_fail++; $display("FAIL parity_07: bit wrong (start %0d), want 1", s1); end
    n_checks++; if (s1 < 0 || tr[0][s2 + (DW + 1) * CPB + 1] !== 1'b0) begin n_fail++; $display("FAIL parity_03: bit wrong (start %0d), want 0", s2); end
    n_checks++; if (d1 - s1 + 1 !== 44) begin n_fail++; $display("FAIL parity_frame_len: got %0d want 44", d1 - s1 + 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_empty_boundary();
    test_full_drain();
    test_back_to_back();
    test_random();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for fifo_top. Pops words from the FIFO read port and serialises each one onto a single UART-style line.
- Frame format: 1 start bit (0), DATA_WIDTH data bits LSB-first, 1 stop bit (1).
- Runs continuously while the FIFO is non-empty and gives back-pressure through the pop strobe.

Parameters:
DATA_WIDTH, 8, word width; must match the fifo_top DATA_WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
CNT_WIDTH, 16, width of the baud counter; must satisfy CLKS_PER_BIT < 2**CNT_WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rstn  input  1  asynchronous reset, active-high. Polarity is fixed despite the name.
i_fifo_empty  input  1  fifo_empty from fifo_top.
i_fifo_data  input  DATA_WIDTH  o_data from fifo_top; valid the cycle after o_fifo_rd is high.
o_fifo_rd  output  1  drives fifo_top i_rd; single-cycle pop strobe.
o_tx  output  1  serial line, idle high.
o_busy  output  1  high from the POP state through the end of the STOP state.
o_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (rstn=1, async): o_tx=1, o_fifo_rd=0, o_busy=0, o_done=0. State=IDLE; shift register, bit counter and baud counter cleared.
- Reset mid-frame: line returns high immediately and the current word is lost. The FIFO is not re-read.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP (PARITY is added when the optional feature is compiled in).
- IDLE: if i_fifo_empty=0, go to POP; otherwise stay.
- POP: o_fifo_rd=1 for exactly this one cycle, then go to LOAD.
- LOAD: capture i_fifo_data into the shift register, clear the baud counter, go to START. o_fifo_rd=0.
- START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA: o_tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit counter. After bit DATA_WIDTH-1, go to STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles. o_done=1 on the final cycle.
  - Leaving STOP: if i_fifo_empty=0, go directly to POP (back-to-back frames); otherwise go to IDLE.
- Timing:
  - Pop strobe to start-bit leading edge is 2 cycles.
  - Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - Inter-frame gap is 2 cycles (POP, LOAD) of idle-high.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; no drift accumulates across bits.
- Empty boundary: a pop is never issued while i_fifo_empty=1. An underflow strobe is therefore impossible.
- i_fifo_empty is sampled only in IDLE and on the last STOP cycle. Writes arriving mid-frame are drained by the following frame.
- Simultaneous FIFO write and drain is legal. This block depends only on the empty flag.
- o_busy=0 only in IDLE.
- o_tx is driven from a register (no combinational glitches).

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. o_tx carries the even parity of the captured word (XOR of all data bits) for CLKS_PER_BIT cycles. Frame length becomes (DATA_WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; frame as described above.

Test Plan:
1. Reset check: assert rstn mid-DATA with CLKS_PER_BIT=4 -> o_tx=1, o_busy=0 and o_fifo_rd=0 asynchronously. Line stays idle while the FIFO is empty.
2. Single word: write 8'hA5 into fifo_top, CLKS_PER_BIT=4.
   - One o_fifo_rd pulse.
   - o_tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   - o_done pulses once, 40 cycles after the start edge.
3. Full drain: fill the FIFO to fifo_full with 8 random words -> 8 frames in write order, each separated by a 2-cycle idle gap. Exactly 8 pops; fifo_empty=1 after the 8th pop. Returns to IDLE.
4. Empty boundary: keep the FIFO empty for 100 cycles -> o_fifo_rd never asserts and o_tx stays 1.
5. Concurrent write: write 8'h3C during frame 1 of 8'h0F -> 8'h3C is popped on the cycle after frame 1's STOP (back-to-back). Bit order is verified LSB-first.
6. With FIFO_UART_TX_PARITY_EN: send 8'h07 -> parity bit 1; send 8'h03 -> parity bit 0. Frame length is 44 cycles at CLKS_PER_BIT=4.
